seq_mem_arb_d1: RTL
===================

SEQ_MEM_ARB_D1 -- requirements
Module: seq_mem_arb_d1

Interface
REQ-001 Parameter WIDTH, default 32: data word width.
REQ-002 Parameter SIZE, default 8: number of memory words.
REQ-003 Parameter IDX_SIZE, default 5: address width.
REQ-004 clk  input  1: clock; all state changes on the rising edge.
REQ-005 reset  input  1: reset, synchronous, active-high.
REQ-006 rd_valid / rd_ready  input / output  1 / 1: read request handshake.
REQ-007 rd_addr  input  IDX_SIZE: read address.
REQ-008 wr_valid / wr_ready  input / output  1 / 1: write request handshake.
REQ-009 wr_addr / wr_data  input  IDX_SIZE / WIDTH: write address and data.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1: read response handshake.
REQ-011 rsp_data / rsp_err  output  WIDTH / 1: read data and out-of-bounds flag.
REQ-012 wr_ack / wr_err  output  1 / 1: one-cycle write-complete pulse and out-of-bounds flag.
REQ-013 mem_addr0  output  IDX_SIZE: address to the downstream memory.
REQ-014 mem_read_en / mem_write_en  output  1 / 1: memory commands.
REQ-015 mem_in  output  WIDTH: write data to the memory.
REQ-016 mem_out / mem_read_done / mem_write_done  input  WIDTH / 1 / 1: memory read data and completions.
REQ-017 rd_cnt / wr_cnt  output  8 / 8: saturating counts of completed in-bounds reads and writes.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ISSUE, RD_WAIT, RESP, WR_ISSUE and WR_WAIT.
REQ-019 rd_ready and wr_ready SHALL be high only in IDLE, and SHALL be masked by arbitration: at most one request is accepted per cycle.
REQ-020 When both requests are valid in IDLE, the grant SHALL go to the type not granted last; last_grant resets to write, so the first contended grant goes to read.
REQ-021 An accepted in-bounds read (addr < SIZE) SHALL latch the address and move to RD_ISSUE.
REQ-022 An accepted in-bounds write SHALL latch address and data and move to WR_ISSUE.
REQ-023 RD_ISSUE SHALL assert mem_read_en for exactly one cycle with mem_addr0 set to the latched address, then move to RD_WAIT.
REQ-024 WR_ISSUE SHALL assert mem_write_en for exactly one cycle with mem_addr0 and mem_in set, then move to WR_WAIT.
REQ-025 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-026 mem_read_en and mem_write_en SHALL be low in every state other than their ISSUE state.
REQ-027 In RD_WAIT, on mem_read_done the block SHALL capture mem_out into rsp_data, set rsp_err=0, and move to RESP.
REQ-028 In WR_WAIT, on mem_write_done the block SHALL pulse wr_ack=1 with wr_err=0 in the following cycle and return to IDLE.
REQ-029 RESP SHALL hold rsp_valid=1 with rsp_data stable until rsp_ready=1 is sampled, then return to IDLE.
REQ-030 An accepted out-of-bounds read (addr >= SIZE) SHALL issue no memory command and go directly to RESP with rsp_data=0 and rsp_err=1.
REQ-031 An accepted out-of-bounds write SHALL issue no memory command, pulse wr_ack=1 with wr_err=1 in the next cycle, and remain in IDLE.
REQ-032 Read latency, with acceptance at edge E and a memory done one cycle after issue: mem_read_en is high in E..E+1, rsp_valid rises at E+3.
REQ-033 Write latency, with acceptance at edge E: mem_write_en is high in E..E+1 and wr_ack is high in E+3..E+4.
REQ-034 A mem_read_done or mem_write_done arriving outside its WAIT state SHALL be ignored.
REQ-035 rd_cnt SHALL increment on each in-bounds read completion and saturate at 255.
REQ-036 wr_cnt SHALL increment on each in-bounds write completion and saturate at 255.
REQ-037 mem_addr0 and mem_in SHALL hold their last values when no command is issued.

Reset
REQ-038 On reset the FSM SHALL go to IDLE from any state, including mid-operation, and any in-flight operation SHALL be discarded with no response or ack.
REQ-039 On reset the outputs SHALL be: rsp_valid=0, rsp_data=0, rsp_err=0, wr_ack=0, wr_err=0, mem_read_en=0, mem_write_en=0, rd_cnt=0, wr_cnt=0, last_grant=write.
REQ-040 rd_ready and wr_ready SHALL be 0 while reset is high.

Verification
REQ-041 Write addr 3 data 0xDEADBEEF, then read addr 3 -> mem_write_en pulse then wr_ack; rsp_valid with rsp_data=0xDEADBEEF, rsp_err=0, rd_cnt=1, wr_cnt=1.
REQ-042 rd_valid and wr_valid asserted together in IDLE after reset, twice -> read granted first, write second; the memory enables are never high together.
REQ-043 Read addr 9 with SIZE=8 -> no mem_read_en; rsp_valid with rsp_data=0 and rsp_err=1; rd_cnt unchanged.
REQ-044 rsp_ready held low for 5 cycles during RESP -> rsp_valid and rsp_data stable; rd_ready=0 and wr_ready=0 throughout.
REQ-045 Reset asserted in RD_WAIT -> next cycle IDLE, rsp_valid=0, and a subsequent late mem_read_done is ignored.
REQ-046 300 in-bounds writes -> wr_cnt saturates at 255.

Source files
------------

// File: rtl/seq_mem_arb_d1_if.sv
// rtl/seq_mem_arb_d1_if.sv - request/response and memory-side bundle for the read/write memory arbiter
interface seq_mem_arb_d1_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 5
);
    logic                rd_valid;
    logic                rd_ready;
    logic [IDX_SIZE-1:0] rd_addr;
    logic                wr_valid;
    logic                wr_ready;
    logic [IDX_SIZE-1:0] wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_data;
    logic                rsp_err;
    logic                wr_ack;
    logic                wr_err;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic                mem_read_en;
    logic                mem_write_en;
    logic [WIDTH-1:0]    mem_in;
    logic [WIDTH-1:0]    mem_out;
    logic                mem_read_done;
    logic                mem_write_done;
    logic [7:0]          rd_cnt;
    logic [7:0]          wr_cnt;

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready,
               mem_out, mem_read_done, mem_write_done,
        output rd_ready, wr_ready, rsp_valid, rsp_data, rsp_err, wr_ack, wr_err,
               mem_addr0, mem_read_en, mem_write_en, mem_in, rd_cnt, wr_cnt
    );

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready,
               mem_out, mem_read_done, mem_write_done,
        input  rd_ready, wr_ready, rsp_valid, rsp_data, rsp_err, wr_ack, wr_err,
               mem_addr0, mem_read_en, mem_write_en, mem_in, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/seq_mem_arb_d1.sv
// rtl/seq_mem_arb_d1.sv - single-port memory arbiter serialising read and write requests
module seq_mem_arb_d1 #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 8,
    parameter int IDX_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_mem_arb_d1_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_RESP, S_WR_ISSUE, S_WR_WAIT
    } state_t;

    localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);

    state_t              state_q, state_d;
    logic                last_rd_q, last_rd_d;
    logic [IDX_SIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic [7:0]          rd_cnt_q, rd_cnt_d;
    logic [7:0]          wr_cnt_q, wr_cnt_d;

    logic idle, rd_grant, wr_grant, rd_oob, wr_oob;

    // Contention goes to the type not granted last; last_rd_q=0 means write was last.
    always_comb begin
        idle          = (state_q == S_IDLE);
        bus.rd_ready  = idle & ~reset & (~bus.wr_valid | ~last_rd_q);
        bus.wr_ready  = idle & ~reset & (~bus.rd_valid |  last_rd_q);
        rd_grant      = bus.rd_valid & bus.rd_ready;
        wr_grant      = bus.wr_valid & bus.wr_ready;
        rd_oob        = ({1'b0, bus.rd_addr} >= SIZE_W);
        wr_oob        = ({1'b0, bus.wr_addr} >= SIZE_W);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_grant)                state_d = rd_oob ? S_RESP : S_RD_ISSUE;
                else if (wr_grant && !wr_oob) state_d = S_WR_ISSUE;
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT:  if (bus.mem_read_done)  state_d = S_RESP;
            S_RESP:     if (bus.rsp_ready)      state_d = S_IDLE;
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_WR_WAIT:  if (bus.mem_write_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read_en  = (state_q == S_RD_ISSUE);
        bus.mem_write_en = (state_q == S_WR_ISSUE);
        bus.mem_addr0    = addr_q;
        bus.mem_in       = wdata_q;
        bus.rsp_valid    = (state_q == S_RESP);
        bus.rsp_data     = rsp_data_q;
        bus.rsp_err      = rsp_err_q;
        bus.wr_ack       = wr_ack_q;
        bus.wr_err       = wr_err_q;
        bus.rd_cnt       = rd_cnt_q;
        bus.wr_cnt       = wr_cnt_q;
    end

    always_comb begin
        last_rd_d  = last_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (rd_grant) begin
            last_rd_d = 1'b1;
            if (rd_oob) begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
            end else begin
                addr_d = bus.rd_addr;
            end
        end
        if (wr_grant) begin
            last_rd_d = 1'b0;
            if (wr_oob) begin
                wr_ack_d = 1'b1;
                wr_err_d = 1'b1;
            end else begin
                addr_d  = bus.wr_addr;
                wdata_d = bus.wr_data;
            end
        end
        // Completions outside their WAIT state fall through untouched.
        if (state_q == S_RD_WAIT && bus.mem_read_done) begin
            rsp_data_d = bus.mem_out;
            rsp_err_d  = 1'b0;
            if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
        end
        if (state_q == S_WR_WAIT && bus.mem_write_done) begin
            wr_ack_d = 1'b1;
            wr_err_d = 1'b0;
            if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_rd_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_cnt_q   <= 8'd0;
            wr_cnt_q   <= 8'd0;
        end else begin
            last_rd_q  <= last_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end
endmodule
